mux_rr_sel: RTL



---
 rtl/mux_rr_sel.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mux_rr_sel.sv
// Two-requester round-robin arbiter driving the select of a downstream 2:1 mux.
// Define MUX_BURST_LIMIT_EN to force a handoff after MAX_BURST granted cycles when contended.
module mux_rr_sel #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             busy,
  output logic [CNT_W-1:0] burst_cnt
);

  typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntSat = {CNT_W{1'b1}};

  // Reject parameter values the burst counter cannot represent.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
  if (MAX_BURST < 1 || MAX_BURST > (2 ** CNT_W) - 1) begin : g_bad_max_burst
    $error("MAX_BURST out of range for CNT_W");
  end

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_b_q, last_b_d;  // 1: B was the most recent owner
  logic             take_a, take_b;
  logic             at_limit;

`ifdef MUX_BURST_LIMIT_EN
  assign at_limit = (cnt_q == CNT_W'(MAX_BURST));
`else
  assign at_limit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    take_a   = 1'b0;
    take_b   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_a && (!req_b || last_b_q)) begin
          take_a = 1'b1;
        end else if (req_b) begin
          take_b = 1'b1;
        end
      end
      StOwnA: begin
        if (!req_a) begin
          if (req_b) take_b = 1'b1;
          else       state_d = StIdle;
        end else if (at_limit && req_b) begin
          take_b = 1'b1;
        end else if (cnt_q != CntSat) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StOwnB: begin
        if (!req_b) begin
          if (req_a) take_a = 1'b1;
          else       state_d = StIdle;
        end else if (at_limit && req_a) begin
          take_a = 1'b1;
        end else if (cnt_q != CntSat) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase

    // No owner means no granted cycles to report; sel is left untouched.
    if (state_d == StIdle) begin
      cnt_d = '0;
    end

    if (take_a) begin
      state_d  = StOwnA;
      sel_d    = 1'b0;
      cnt_d    = CntOne;
      last_b_d = 1'b0;
    end else if (take_b) begin
      state_d  = StOwnB;
      sel_d    = 1'b1;
      cnt_d    = CntOne;
      last_b_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
    end
  end

  assign gnt_a     = (state_q == StOwnA);
  assign gnt_b     = (state_q == StOwnB);
  assign busy      = (state_q != StIdle);
  assign sel       = sel_q;
  assign burst_cnt = cnt_q;

endmodule
